// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the serial shift sequencer: FSM encodings,
// direction constants and default sizes.
package shift_sequencer_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Enables presented to the datapath each cycle; at most one is set.
    typedef struct packed {
        logic load;
        logic shl;
        logic shr;
    } dp_ctrl_t;

endpackage

// File: rtl/shift_sequencer_datapath.sv
// WIDTH-bit serial shift register: parallel load, one-bit logical shift
// left or right per enabled cycle, and the bit that the active shift drops.
module shift_datapath
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  dp_ctrl_t         ctrl,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             out_bit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ctrl.load) begin
            q <= data;
        end else if (ctrl.shl) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end else if (ctrl.shr) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    // Right shifts drop the LSB, everything else reports the MSB.
    assign out_bit = ctrl.shr ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: accepts one command in IDLE, issues AMOUNT
// single-bit shifts on the serial datapath, then pulses done for one cycle.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    dp_ctrl_t         ctrl;
    logic             out_bit;

    always_comb begin
        ctrl      = '0;
        ctrl.load = (state == ST_IDLE) && start;
        ctrl.shl  = (state == ST_SHIFT) && (dir_q == DIR_LEFT);
        ctrl.shr  = (state == ST_SHIFT) && (dir_q == DIR_RIGHT);
    end

    shift_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl    (ctrl),
        .data    (data_in),
        .q       (result),
        .out_bit (out_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir_q <= DIR_LEFT;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dir_q <= dir;
                        cnt   <= amount;
                        carry <= 1'b0;
                        busy  <= 1'b1;
                        // A zero-distance shift goes straight to completion.
                        if (amount != '0) begin
                            state <= ST_SHIFT;
                            done  <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    carry <= out_bit;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign zero = (result == '0);

endmodule
